io_out_arbiter: RTL and testbench
=================================

// Module: io_out_arbiter
// PURPOSE
//  Shares one output peripheral bus among NCORES processor cores in multicore builds.
//  Cores have no stall input, so each out_en write (io_out, addr_out) is captured in a
//  per-core FIFO. FIFOs are drained round-robin into one registered valid/ready port.
//  Sits between the cores' io_out/addr_out/out_en outputs and the shared output decoder.
// PARAMETERS
//  NCORES  2   number of cores (>=2)
//  NUBITS  16  processor word width
//  NUIOOU  2   output ports per core (>=2); AW = $clog2(NUIOOU)
//  FDEPTH  4   entries per core FIFO (power of 2, >=2)
// PORTS
//  clk     in   1            clock, rising edge
//  rst     in   1            asynchronous reset, active-high
//  out_en  in   NCORES       per-core write strobe, bit i = core i
//  io_out  in   NCORES*NUBITS  per-core data, core i at [i*NUBITS +: NUBITS]
//  addr_out in  NCORES*AW    per-core port address, core i at [i*AW +: AW]
//  m_valid out  1            output word valid
//  m_ready in   1            downstream accepts word this cycle
//  m_data  out  NUBITS       data
//  m_addr  out  AW           port address
//  m_core  out  $clog2(NCORES)  index of originating core
//  ovf     out  NCORES       sticky overflow per core
//  busy    out  1            any FIFO non-empty or m_valid
// BEHAVIOUR
//  Reset: all FIFOs empty, m_valid=0, m_data=0, m_addr=0, m_core=0, ovf=0, busy=0,
//   round-robin pointer last=NCORES-1, so core 0 has first priority.
//  Push: out_en[i] sampled at edge k writes {addr_out_i,io_out_i} into FIFO i.
//  Full FIFO i + out_en[i]: accept only if FIFO i pops in the same cycle. Otherwise
//   drop the word and set ovf[i]=1. ovf[i] clears only on reset.
//  Output register, 2 states:
//   EMPTY (m_valid=0) or FULL (m_valid=1).
//   load = (!m_valid | m_ready) & any FIFO non-empty.
//   On load: pop the granted FIFO. m_data, m_addr and m_core take its head. m_valid=1.
//   last=granted index.
//   FULL & m_ready & nothing to load -> EMPTY. FULL & !m_ready -> all outputs held stable.
//  Grant: first non-empty FIFO scanning last+1, last+2, ... modulo NCORES (wrap).
//  Latency: idle system, out_en at edge k gives m_valid=1 after edge k+1 (1 cycle).
//  Throughput: 1 word/cycle while m_ready=1. Per-core order is preserved.
//  Starvation: a continuously non-empty core is granted within NCORES loads.
//  Simultaneous push and pop on the same FIFO: both take effect; count is unchanged.
//  m_ready while m_valid=0 is ignored. rst mid-transfer discards all queued words.
//  busy = |fifo_nonempty | m_valid (combinational).
// STRUCTURE
//  No shared package. Widths are local $clog2 localparams; entry width = AW+NUBITS.
//  One sub-module, io_fifo (sync FIFO: push, pop, din, dout, empty, full, async rst),
//   instanced NCORES times. dout shows the head combinationally.
//  Top-level logic: round-robin grant, output register, ovf flags.
// TESTING
//  1 single: core0 out_en, io_out=16'h1234, addr=1, m_ready=1 -> next cycle
//    m_valid=1, m_data=1234, m_addr=1, m_core=0; busy=0 after accept.
//  2 contention: both cores write every cycle for 4 cycles, m_ready=1 ->
//    output core order 0,1,0,1,... and per-core data order preserved.
//  3 backpressure: m_ready=0 for 10 cycles while core1 writes 3 words ->
//    m_data is stable throughout; after release the 3 words arrive in order.
//  4 overflow: m_ready=0, core0 writes FDEPTH+2 words -> ovf[0]=1 and ovf[1]=0;
//    after release exactly FDEPTH+1 words are delivered (FIFO plus output register).
//  5 full push+pop: FIFO0 full and m_ready=1 with out_en[0] in the same cycle ->
//    no drop and ovf[0] stays 0.
//  6 reset: rst pulses mid-stream with m_valid=1 -> m_valid=0, ovf=0 and busy=0
//    immediately (async); after release core 0 has first priority.

Source files
------------

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - per-core synchronous FIFO with combinational head output
//
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   push, din    write strobe and entry; ignored when full unless pop is also set
//   pop          remove head; ignored when empty
//   dout         current head entry (valid whenever empty=0)
//   empty, full  occupancy flags
module io_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         empty,
    output logic         full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a word when its head leaves on the same edge;
    // the write lands in the slot being vacated.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_out_arbiter.sv
// rtl/io_out_arbiter.sv - round-robin merge of per-core output writes onto one valid/ready port
//
// Ports:
//   clk, rst   clock (rising edge), asynchronous active-high reset
//   out_en     per-core write strobe, bit i = core i
//   io_out     per-core data, core i at [i*NUBITS +: NUBITS]
//   addr_out   per-core port address, core i at [i*AW +: AW]
//   m_valid    output word valid
//   m_ready    downstream accepts the word this cycle
//   m_data     data word
//   m_addr     port address
//   m_core     originating core index
//   ovf        sticky per-core overflow (word dropped on a full FIFO)
//   busy       any FIFO non-empty or output word pending
module io_out_arbiter #(
    parameter int NCORES = 2,
    parameter int NUBITS = 16,
    parameter int NUIOOU = 2,
    parameter int FDEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NCORES-1:0]             out_en,
    input  logic [NCORES*NUBITS-1:0]      io_out,
    input  logic [NCORES*$clog2(NUIOOU)-1:0] addr_out,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [NUBITS-1:0]             m_data,
    output logic [$clog2(NUIOOU)-1:0]     m_addr,
    output logic [$clog2(NCORES)-1:0]     m_core,
    output logic [NCORES-1:0]             ovf,
    output logic                          busy
);

    localparam int AW = $clog2(NUIOOU);
    localparam int CW = $clog2(NCORES);
    localparam int EW = AW + NUBITS;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [EW-1:0]   head [NCORES];
    logic [NCORES-1:0] fifo_empty;
    logic [NCORES-1:0] fifo_full;
    logic [NCORES-1:0] fifo_nonempty;
    logic [NCORES-1:0] pop_vec;
    logic [CW-1:0]   last;
    logic [CW-1:0]   grant_idx;
    logic            grant_valid;
    logic            load;

    for (genvar g = 0; g < NCORES; g++) begin : g_fifo
        io_fifo #(
            .W     (EW),
            .DEPTH (FDEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (out_en[g]),
            .pop   (pop_vec[g]),
            .din   ({addr_out[g*AW +: AW], io_out[g*NUBITS +: NUBITS]}),
            .dout  (head[g]),
            .empty (fifo_empty[g]),
            .full  (fifo_full[g])
        );
    end

    assign fifo_nonempty = ~fifo_empty;
    assign m_valid       = (state_q == ST_FULL);
    assign load          = (!m_valid || m_ready) && grant_valid;
    assign busy          = (|fifo_nonempty) || m_valid;

    // Scan from the core after the last winner, wrapping, so every
    // non-empty core is served within NCORES loads.
    always_comb begin : p_grant
        int idx;
        idx         = 0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int off = 1; off <= NCORES; off++) begin
            idx = (int'(last) + off) % NCORES;
            if (!grant_valid && fifo_nonempty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CW'(idx);
            end
        end
    end

    always_comb begin
        pop_vec = '0;
        if (load) begin
            pop_vec[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (load) state_d = ST_FULL;
            ST_FULL:  if (load) state_d = ST_FULL;
                      else if (m_ready) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data <= '0;
            m_addr <= '0;
            m_core <= '0;
            last   <= CW'(NCORES - 1);
        end else if (load) begin
            m_data <= head[grant_idx][NUBITS-1:0];
            m_addr <= head[grant_idx][EW-1:NUBITS];
            m_core <= grant_idx;
            last   <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= '0;
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (out_en[i] && fifo_full[i] && !pop_vec[i]) begin
                    ovf[i] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_io_out_arbiter.sv
// tb/tb_io_out_arbiter.sv - directed self-checking bench for io_out_arbiter
module tb_io_out_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  out_en;
    logic [31:0] io_out;
    logic [1:0]  addr_out;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic [0:0]  m_addr;
    logic [0:0]  m_core;
    logic [1:0]  ovf;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] got [$];
    logic [31:0] exp_q [$];

    io_out_arbiter #(
        .NCORES (2),
        .NUBITS (16),
        .NUIOOU (2),
        .FDEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .out_en   (out_en),
        .io_out   (io_out),
        .addr_out (addr_out),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_addr   (m_addr),
        .m_core   (m_core),
        .ovf      (ovf),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack(input logic c, input logic a, input logic [15:0] d);
        return {14'd0, c, a, d};
    endfunction

    task automatic drive(input logic [1:0] en, input logic [15:0] d0, input logic [15:0] d1,
                         input logic a0, input logic a1);
        out_en   = en;
        io_out   = {d1, d0};
        addr_out = {a1, a0};
    endtask

    // One clock: record the word that the coming edge hands over, then step.
    task automatic cycle();
        if (m_valid && m_ready) got.push_back(pack(m_core[0], m_addr[0], m_data));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        m_ready = 1'b0;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        got.delete();
    endtask

    task automatic drain(input int target);
        for (int n = 0; n < 30 && got.size() < target; n++) cycle();
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("%s_w%0d", tag, i), (i < got.size()) ? got[i] : 32'hdead_beef, exp_q[i]);
        end
        got.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        m_ready = 1'b0;
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_data", m_data, 0);
        check("rst_core", m_core, 0);
        rst = 1'b0;

        // 1: single word, one-cycle latency
        drive(2'b01, 16'h1234, 16'h0, 1'b1, 1'b0);
        m_ready = 1'b1;
        cycle();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("t1_latency_valid", m_valid, 0);
        cycle();
        check("t1_valid", m_valid, 1);
        check("t1_data", m_data, 16'h1234);
        check("t1_addr", m_addr, 1);
        check("t1_core", m_core, 0);
        cycle();
        check("t1_valid_after", m_valid, 0);
        check("t1_busy_after", busy, 0);
        got.delete();

        // 2: both cores every cycle, alternating grant from core 0
        do_reset();
        m_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            drive(2'b11, 16'hA000 + 16'(n), 16'hB000 + 16'(n), n[0], ~n[0]);
            cycle();
        end
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        drain(8);
        for (int n = 0; n < 4; n++) begin
            exp_q.push_back(pack(1'b0, n[0], 16'hA000 + 16'(n)));
            exp_q.push_back(pack(1'b1, ~n[0], 16'hB000 + 16'(n)));
        end
        compare_words("t2");
        check("t2_ovf", ovf, 0);

        // 3: backpressure holds the output register stable
        m_ready = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (n < 3) drive(2'b10, 16'h0, 16'hC000 + 16'(n), 1'b0, n[0]);
            else drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
            cycle();
            if (n >= 1) begin
                check($sformatf("t3_stable%0d", n), {m_valid, m_data}, {1'b1, 16'hC000});
            end
        end
        m_ready = 1'b1;
        drain(3);
        for (int n = 0; n < 3; n++) exp_q.push_back(pack(1'b1, n[0], 16'hC000 + 16'(n)));
        compare_words("t3");

        // 4: overflow on core 0, FDEPTH+1 survivors
        do_reset();
        for (int n = 0; n < 6; n++) begin
            drive(2'b01, 16'hD000 + 16'(n), 16'h0, n[0], 1'b0);
            cycle();
        end
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("t4_ovf", ovf, 2'b01);
        m_ready = 1'b1;
        for (int n = 0; n < 12; n++) cycle();
        for (int n = 0; n < 5; n++) exp_q.push_back(pack(1'b0, n[0], 16'hD000 + 16'(n)));
        compare_words("t4");
        check("t4_ovf_sticky", ovf, 2'b01);

        // 5: push into full FIFO while it pops
        do_reset();
        for (int n = 0; n < 5; n++) begin
            drive(2'b01, 16'hE000 + 16'(n), 16'h0, 1'b0, 1'b0);
            cycle();
        end
        m_ready = 1'b1;
        drive(2'b01, 16'hE005, 16'h0, 1'b1, 1'b0);
        cycle();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("t5_ovf", ovf, 0);
        drain(6);
        for (int n = 0; n < 5; n++) exp_q.push_back(pack(1'b0, 1'b0, 16'hE000 + 16'(n)));
        exp_q.push_back(pack(1'b0, 1'b1, 16'hE005));
        compare_words("t5");

        // 6: async reset mid-stream, then core 0 wins first
        do_reset();
        for (int n = 0; n < 6; n++) begin
            drive(2'b10, 16'h0, 16'hF000 + 16'(n), 1'b0, 1'b0);
            cycle();
        end
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        check("t6_pre_valid", m_valid, 1);
        check("t6_pre_ovf", ovf, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_valid", m_valid, 0);
        check("t6_rst_ovf", ovf, 0);
        check("t6_rst_busy", busy, 0);
        rst = 1'b0;
        got.delete();
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        drive(2'b11, 16'h5A5A, 16'hA5A5, 1'b0, 1'b1);
        cycle();
        drive(2'b00, 16'h0, 16'h0, 1'b0, 1'b0);
        cycle();
        check("t6_first", pack(m_core[0], m_addr[0], m_data), pack(1'b0, 1'b0, 16'h5A5A));
        cycle();
        check("t6_second", pack(m_core[0], m_addr[0], m_data), pack(1'b1, 1'b1, 16'hA5A5));
        cycle();
        check("t6_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
